// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcode/funct constants, ALU and writeback codes,
// and the decoded control bundle shared by decode_comb and decode_stage.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10,
    ALU_EQ     = 4'd11,
    ALU_NE     = 4'd12,
    ALU_LT     = 4'd13,
    ALU_GE     = 4'd14,
    ALU_LTU    = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        alu_imm;
    logic        alu_pc;
    wb_sel_e     wb_sel;
    logic        w_en_rf;
    logic        wr_en_dmem;
    logic [3:0]  rw_mode;
    logic        branch;
    logic        jump;
    logic        illegal;
`ifdef RV32M_EN
    logic        mdu_en;
    logic [2:0]  mdu_op;
`endif
  } ctrl_t;

  function automatic alu_op_e alu_op_of(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    op = ALU_ADD;
    unique case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side input handshake and execute-side decoded bundle.
// master = producer/consumer around the stage, slave = decode_stage.
// Optional mdu_en/mdu_op exist only when RV32M_EN is defined.
interface decode_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic [3:0]      alu_op_select;
  logic            alu_imm_select;
  logic            alu_pc_select;
  logic [1:0]      rf_w_select;
  logic            w_en_rf;
  logic            wr_en_dmem;
  logic [3:0]      rw_mode;
  logic            branch;
  logic            jump;
  logic            illegal;
`ifdef RV32M_EN
  logic            mdu_en;
  logic [2:0]      mdu_op;
`endif

  modport master (
    output in_valid, instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc,
    input  rs1, rs2, rd, imm,
    input  alu_op_select, alu_imm_select, alu_pc_select,
    input  rf_w_select, w_en_rf, wr_en_dmem, rw_mode,
    input  branch, jump, illegal
`ifdef RV32M_EN
    , input mdu_en, mdu_op
`endif
  );

  modport slave (
    input  in_valid, instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc,
    output rs1, rs2, rd, imm,
    output alu_op_select, alu_imm_select, alu_pc_select,
    output rf_w_select, w_en_rf, wr_en_dmem, rw_mode,
    output branch, jump, illegal
`ifdef RV32M_EN
    , output mdu_en, mdu_op
`endif
  );

endinterface

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I decoder, instr_i -> ctrl_o bundle,
// plus load / register-use flags for the hazard tracker. Honours RV32M_EN.
module decode_comb
  import decode_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        is_load_o,
  output logic        rs1_used_o,
  output logic        rs2_used_o
);

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        use_rd, ill, ld;

  assign opc = instr_i[6:0];
  assign rd  = instr_i[11:7];
  assign f3  = instr_i[14:12];
  assign rs1 = instr_i[19:15];
  assign rs2 = instr_i[24:20];
  assign f7  = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                  instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                  instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    ctrl_o     = '0;
    use_rd     = 1'b0;
    ill        = 1'b0;
    ld         = 1'b0;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    unique case (1'b1)
      (opc == OPC_LUI): begin
        use_rd         = 1'b1;
        ctrl_o.imm     = imm_u;
        ctrl_o.alu_op  = ALU_PASS_B;
        ctrl_o.alu_imm = 1'b1;
        ctrl_o.wb_sel  = WB_IMM;
      end
      (opc == OPC_AUIPC): begin
        use_rd         = 1'b1;
        ctrl_o.imm     = imm_u;
        ctrl_o.alu_imm = 1'b1;
        ctrl_o.alu_pc  = 1'b1;
      end
      (opc == OPC_JAL): begin
        use_rd         = 1'b1;
        ctrl_o.imm     = imm_j;
        ctrl_o.alu_imm = 1'b1;
        ctrl_o.alu_pc  = 1'b1;
        ctrl_o.wb_sel  = WB_PC4;
        ctrl_o.jump    = 1'b1;
      end
      (opc == OPC_JALR): begin
        use_rd         = 1'b1;
        rs1_used_o     = 1'b1;
        ill            = (f3 != 3'b000);
        ctrl_o.imm     = imm_i;
        ctrl_o.alu_imm = 1'b1;
        ctrl_o.wb_sel  = WB_PC4;
        ctrl_o.jump    = 1'b1;
      end
      (opc == OPC_BRANCH): begin
        rs1_used_o    = 1'b1;
        rs2_used_o    = 1'b1;
        ctrl_o.imm    = imm_b;
        ctrl_o.branch = 1'b1;
        unique case (f3)
          3'b000:  ctrl_o.alu_op = ALU_EQ;
          3'b001:  ctrl_o.alu_op = ALU_NE;
          3'b100:  ctrl_o.alu_op = ALU_LT;
          3'b101:  ctrl_o.alu_op = ALU_GE;
          3'b110:  ctrl_o.alu_op = ALU_LTU;
          // BGEU has no compare code: execute takes on !SLTU
          3'b111:  ctrl_o.alu_op = ALU_SLTU;
          default: ill = 1'b1;
        endcase
      end
      (opc == OPC_LOAD): begin
        use_rd         = 1'b1;
        rs1_used_o     = 1'b1;
        ld             = 1'b1;
        ill            = (f3 == 3'b011) || (f3 == 3'b110) ||
                         (f3 == 3'b111);
        ctrl_o.imm     = imm_i;
        ctrl_o.alu_imm = 1'b1;
        ctrl_o.wb_sel  = WB_MEM;
        ctrl_o.rw_mode = {1'b0, f3};
      end
      (opc == OPC_STORE): begin
        rs1_used_o        = 1'b1;
        rs2_used_o        = 1'b1;
        ill               = (f3[2] || f3 == 3'b011);
        ctrl_o.imm        = imm_s;
        ctrl_o.alu_imm    = 1'b1;
        ctrl_o.wr_en_dmem = 1'b1;
        ctrl_o.rw_mode    = {1'b1, f3};
      end
      (opc == OPC_OPIMM): begin
        use_rd         = 1'b1;
        rs1_used_o     = 1'b1;
        ctrl_o.imm     = imm_i;
        ctrl_o.alu_imm = 1'b1;
        ctrl_o.alu_op  = alu_op_of(f3, f3 == F3_SR && f7 == F7_ALT);
        if (f3 == F3_SLL)
          ill = (f7 != F7_BASE);
        else if (f3 == F3_SR)
          ill = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      (opc == OPC_OP): begin
        use_rd     = 1'b1;
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b1;
        unique case (f7)
          F7_BASE: ctrl_o.alu_op = alu_op_of(f3, 1'b0);
          F7_ALT: begin
            ctrl_o.alu_op = alu_op_of(f3, 1'b1);
            ill = (f3 != F3_ADD) && (f3 != F3_SR);
          end
`ifdef RV32M_EN
          F7_MUL: begin
            ctrl_o.mdu_en = 1'b1;
            ctrl_o.mdu_op = f3;
          end
`endif
          default: ill = 1'b1;
        endcase
      end
      (opc == OPC_FENCE): ill = (f3 != 3'b000);
      default: ill = 1'b1;
    endcase

    ctrl_o.rs1     = rs1_used_o ? rs1 : 5'd0;
    ctrl_o.rs2     = rs2_used_o ? rs2 : 5'd0;
    ctrl_o.rd      = use_rd ? rd : 5'd0;
    ctrl_o.w_en_rf = use_rd && (rd != 5'd0);

    if (RV32E && ((rs1_used_o && rs1[4]) ||
                  (rs2_used_o && rs2[4]) ||
                  (use_rd && rd[4])))
      ill = 1'b1;
    if (instr_i[1:0] != 2'b11)
      ill = 1'b1;

    ctrl_o.illegal = ill;
    if (ill) begin
      ctrl_o.w_en_rf    = 1'b0;
      ctrl_o.wr_en_dmem = 1'b0;
      ctrl_o.rw_mode    = 4'd0;
      ctrl_o.branch     = 1'b0;
      ctrl_o.jump       = 1'b0;
`ifdef RV32M_EN
      ctrl_o.mdu_en     = 1'b0;
`endif
    end
    is_load_o = ld && !ill && (rd != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered valid/ready decode stage with load-use bubbles.
// Ports: clk, rst_n (async low), flush, bus (decode_if.slave). Macro: RV32M_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned LOAD_USE_DIST = 1,
  parameter bit          RV32E         = 1'b0
) (
  input logic      clk,
  input logic      rst_n,
  input logic      flush,
  decode_if.slave  bus
);

  ctrl_t           dec, ctrl_q, ctrl_d;
  logic            is_load, rs1_used, rs2_used;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            hazard, fire_in, fire_out;

  decode_comb #(.RV32E(RV32E)) u_comb (
    .instr_i    (bus.instr),
    .ctrl_o     (dec),
    .is_load_o  (is_load),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used)
  );

  // The tracker arms when a load enters this register, so the dependent
  // is held while the load sits here and for LOAD_USE_DIST-1 more advances.
  assign hazard = bus.in_valid && (cnt_q != 3'd0) &&
                  ((rs1_used && dec.rs1 == ld_rd_q) ||
                   (rs2_used && dec.rs2 == ld_rd_q));

  assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !flush;
  assign fire_in      = bus.in_valid && bus.in_ready;
  assign fire_out     = valid_q && bus.out_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    ld_rd_d = ld_rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      cnt_d   = 3'd0;
    end else begin
      if (fire_in) begin
        valid_d = 1'b1;
        ctrl_d  = dec;
        pc_d    = bus.in_pc;
      end else if (fire_out) begin
        valid_d = 1'b0;
      end
      if (fire_in && is_load) begin
        ld_rd_d = dec.rd;
        cnt_d   = 3'(LOAD_USE_DIST);
      end else if (bus.out_ready && cnt_q != 3'd0) begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      ld_rd_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      ld_rd_q <= ld_rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_pc         = pc_q;
  assign bus.rs1            = ctrl_q.rs1;
  assign bus.rs2            = ctrl_q.rs2;
  assign bus.rd             = ctrl_q.rd;
  assign bus.imm            = XLEN'($signed(ctrl_q.imm));
  assign bus.alu_op_select  = ctrl_q.alu_op;
  assign bus.alu_imm_select = ctrl_q.alu_imm;
  assign bus.alu_pc_select  = ctrl_q.alu_pc;
  assign bus.rf_w_select    = ctrl_q.wb_sel;
  assign bus.w_en_rf        = ctrl_q.w_en_rf;
  assign bus.wr_en_dmem     = ctrl_q.wr_en_dmem;
  assign bus.rw_mode        = ctrl_q.rw_mode;
  assign bus.branch         = ctrl_q.branch;
  assign bus.jump           = ctrl_q.jump;
  assign bus.illegal        = ctrl_q.illegal;
`ifdef RV32M_EN
  assign bus.mdu_en         = ctrl_q.mdu_en;
  assign bus.mdu_op         = ctrl_q.mdu_op;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage (RV32I and RV32E builds)
// covering decode fields, load-use bubble, back-pressure, flush and reset.
`define TICK begin @(posedge clk); #1; end

module tb_decode_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  bit   done   = 1'b0;

  decode_if #(.XLEN(32)) bus ();
  decode_if #(.XLEN(32)) bus_e ();

  decode_stage #(.XLEN(32), .LOAD_USE_DIST(1), .RV32E(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  decode_stage #(.XLEN(32), .LOAD_USE_DIST(1), .RV32E(1'b1)) dut_e (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_e.slave)
  );

  assign bus_e.in_valid  = bus.in_valid;
  assign bus_e.instr     = bus.instr;
  assign bus_e.in_pc     = bus.in_pc;
  assign bus_e.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    if (!done) begin
      failed++;
      $error("FAIL timeout: simulation did not complete");
      $finish;
    end
  end

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_illegal", bus.illegal, 1'b0);
    chk("rst_imm", bus.imm, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_w_en_rf", bus.w_en_rf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    `TICK
    chk("rst_in_ready", bus.in_ready, 1'b1);

    bus.instr    = 32'h00418133;
    bus.in_pc    = 32'h100;
    bus.in_valid = 1'b1;
    `TICK
    bus.in_valid = 1'b0;
    chk("add_valid", bus.out_valid, 1'b1);
    chk("add_alu_op", bus.alu_op_select, 4'd0);
    chk("add_w_en", bus.w_en_rf, 1'b1);
    chk("add_rd", bus.rd, 5'd2);
    chk("add_rs1", bus.rs1, 5'd3);
    chk("add_rs2", bus.rs2, 5'd4);
    chk("add_imm", bus.imm, 32'h0);
    chk("add_pc", bus.out_pc, 32'h100);
    `TICK
    chk("add_drain", bus.out_valid, 1'b0);

    bus.instr    = 32'h00822183;
    bus.in_pc    = 32'h200;
    bus.in_valid = 1'b1;
    `TICK
    chk("lw_valid", bus.out_valid, 1'b1);
    chk("lw_rd", bus.rd, 5'd3);
    chk("lw_wsel", bus.rf_w_select, 2'd1);
    chk("lw_rw_mode", bus.rw_mode, 4'h2);
    chk("lw_imm", bus.imm, 32'h8);
    bus.instr = 32'h001182B3;
    bus.in_pc = 32'h204;
    #1;
    chk("lu_hold_ready", bus.in_ready, 1'b0);
    `TICK
    chk("lu_bubble", bus.out_valid, 1'b0);
    chk("lu_release", bus.in_ready, 1'b1);
    `TICK
    bus.in_valid = 1'b0;
    chk("lu_add_valid", bus.out_valid, 1'b1);
    chk("lu_add_pc", bus.out_pc, 32'h204);
    chk("lu_add_rd", bus.rd, 5'd5);
    `TICK

    bus.instr    = 32'h00418113;
    bus.in_pc    = 32'h300;
    bus.in_valid = 1'b1;
    `TICK
    bus.out_ready = 1'b0;
    bus.instr     = 32'h00418133;
    bus.in_pc     = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", bus.in_ready, 1'b0);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_imm", bus.imm, 32'h4);
      chk("bp_pc", bus.out_pc, 32'h300);
      chk("bp_alu_imm", bus.alu_imm_select, 1'b1);
      `TICK
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_accept", bus.in_ready, 1'b1);
    `TICK
    bus.in_valid = 1'b0;
    chk("bp_next_pc", bus.out_pc, 32'h304);
    chk("bp_next_valid", bus.out_valid, 1'b1);
    `TICK

    bus.instr    = 32'h00000000;
    bus.in_pc    = 32'h400;
    bus.in_valid = 1'b1;
    `TICK
    chk("ill_flag", bus.illegal, 1'b1);
    chk("ill_w_en", bus.w_en_rf, 1'b0);
    chk("ill_dmem", bus.wr_en_dmem, 1'b0);
    chk("ill_branch", bus.branch, 1'b0);
    chk("ill_jump", bus.jump, 1'b0);

    bus.instr = 32'h00208A33;
    `TICK
    chk("e_i_illegal", bus.illegal, 1'b0);
    chk("e_i_w_en", bus.w_en_rf, 1'b1);
    chk("e_i_rd", bus.rd, 5'd20);
    chk("e_e_illegal", bus_e.illegal, 1'b1);
    chk("e_e_w_en", bus_e.w_en_rf, 1'b0);

    bus.instr = 32'h00532623;
    `TICK
    chk("sw_dmem", bus.wr_en_dmem, 1'b1);
    chk("sw_rw_mode", bus.rw_mode, 4'hA);
    chk("sw_imm", bus.imm, 32'hC);
    chk("sw_rd", bus.rd, 5'd0);
    chk("sw_w_en", bus.w_en_rf, 1'b0);

    bus.instr = 32'h008000EF;
    `TICK
    chk("jal_jump", bus.jump, 1'b1);
    chk("jal_wsel", bus.rf_w_select, 2'd2);
    chk("jal_imm", bus.imm, 32'h8);
    chk("jal_pc_sel", bus.alu_pc_select, 1'b1);

    bus.instr = 32'hFFF00093;
    `TICK
    chk("neg_imm", bus.imm, 32'hFFFFFFFF);
    chk("neg_rs1", bus.rs1, 5'd0);
    chk("neg_rs2", bus.rs2, 5'd0);

    bus.instr = 32'h023100B3;
    `TICK
    bus.in_valid = 1'b0;
`ifdef RV32M_EN
    chk("mul_mdu_en", bus.mdu_en, 1'b1);
    chk("mul_mdu_op", bus.mdu_op, 3'd0);
    chk("mul_alu_op", bus.alu_op_select, 4'd0);
    chk("mul_illegal", bus.illegal, 1'b0);
`else
    chk("mul_illegal", bus.illegal, 1'b1);
    chk("mul_w_en", bus.w_en_rf, 1'b0);
`endif
    `TICK

    bus.instr    = 32'h00822183;
    bus.in_pc    = 32'h500;
    bus.in_valid = 1'b1;
    `TICK
    flush     = 1'b1;
    bus.instr = 32'h001182B3;
    bus.in_pc = 32'h504;
    #1;
    chk("fl_ready", bus.in_ready, 1'b0);
    `TICK
    flush = 1'b0;
    #1;
    chk("fl_valid", bus.out_valid, 1'b0);
    chk("fl_no_bubble", bus.in_ready, 1'b1);
    `TICK
    bus.in_valid = 1'b0;
    chk("fl_add_valid", bus.out_valid, 1'b1);
    chk("fl_add_pc", bus.out_pc, 32'h504);
    `TICK

    bus.instr    = 32'h00822183;
    bus.in_pc    = 32'h600;
    bus.in_valid = 1'b1;
    `TICK
    bus.out_ready = 1'b0;
    bus.instr     = 32'h001182B3;
    bus.in_pc     = 32'h604;
    `TICK
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_valid", bus.out_valid, 1'b0);
    chk("rr_rd", bus.rd, 5'd0);
    chk("rr_imm", bus.imm, 32'h0);
    chk("rr_pc", bus.out_pc, 32'h0);
    chk("rr_wsel", bus.rf_w_select, 2'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("rr_ready", bus.in_ready, 1'b1);
    `TICK
    bus.in_valid = 1'b0;
    chk("rr_add_valid", bus.out_valid, 1'b1);
    chk("rr_add_rd", bus.rd, 5'd5);

    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
